// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared types and constants for the two-requester ram arbiter
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;
    localparam int STAT_W     = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    function automatic req_id_t other_id(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// rtl/ram_arbiter_rr_arb2.sv - two-way round-robin picker; pointer side wins a tie
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  req_id_t    ptr,
    output logic [1:0] gnt,
    output req_id_t    ptr_nxt
);

    always_comb begin
        gnt     = 2'b00;
        ptr_nxt = ptr;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = (ptr == REQ1) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
        // The loser of this cycle gets priority next time.
        if (gnt[0]) begin
            ptr_nxt = other_id(REQ0);
        end else if (gnt[1]) begin
            ptr_nxt = other_id(REQ1);
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - round-robin sharing of a single-port ram between two requesters
// Optional grant statistics outputs are enabled by defining RAM_ARB_STAT_EN.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_cen,
    output logic              ram_wen,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
`ifdef RAM_ARB_STAT_EN
    ,
    output logic [STAT_W-1:0] stat_cnt0,
    output logic [STAT_W-1:0] stat_cnt1
`endif
);

    logic [1:0]        req_vec;
    logic [1:0]        gnt_vec;
    req_id_t           ptr_q;
    req_id_t           ptr_nxt;
    arb_state_t        state_q;
    arb_state_t        state_nxt;
    logic              any_gnt;
    req_id_t           win_id;
    logic              win_we;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              s1_v;
    logic              s2_v;
    req_id_t           s1_id;
    req_id_t           s2_id;
    logic              rd_ret;
    logic [DATA_W-1:0] rdata_q;

    // Requests are masked during reset so no grant can be issued then.
    assign req_vec = rst ? 2'b00 : {req1, req0};

    rr_arb2 u_rr_arb2 (
        .req     (req_vec),
        .ptr     (ptr_q),
        .gnt     (gnt_vec),
        .ptr_nxt (ptr_nxt)
    );

    assign gnt0      = gnt_vec[0];
    assign gnt1      = gnt_vec[1];
    assign any_gnt   = |gnt_vec;
    assign win_id    = gnt_vec[1] ? REQ1 : REQ0;
    assign win_we    = (win_id == REQ1) ? we1 : we0;
    assign win_addr  = (win_id == REQ1) ? addr1 : addr0;
    assign win_wdata = (win_id == REQ1) ? wdata1 : wdata0;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ0;
        end else begin
            ptr_q <= ptr_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (any_gnt)  state_nxt = ISSUE;
            ISSUE:   if (!any_gnt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_cen = (state_q == ISSUE);

    // Address/data pins keep their last values while the ram is idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_wen  <= 1'b0;
            ram_addr <= '0;
            ram_din  <= '0;
        end else if (any_gnt) begin
            ram_wen  <= win_we;
            ram_addr <= win_addr;
            ram_din  <= win_wdata;
        end
    end

    // Stage 1 tracks the access on the ram pins, stage 2 the cycle its data appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v  <= 1'b0;
            s1_id <= REQ0;
            s2_v  <= 1'b0;
            s2_id <= REQ0;
        end else begin
            s1_v  <= any_gnt & ~win_we;
            s1_id <= win_id;
            s2_v  <= s1_v;
            s2_id <= s1_id;
        end
    end

    assign rd_ret  = s2_v & ~rst;
    assign rvalid0 = rd_ret & (s2_id == REQ0);
    assign rvalid1 = rd_ret & (s2_id == REQ1);

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_ret) begin
            rdata_q <= ram_dout;
        end
    end

    assign rdata = rd_ret ? ram_dout : rdata_q;

`ifdef RAM_ARB_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_cnt0 <= '0;
            stat_cnt1 <= '0;
        end else begin
            if (gnt0 && (stat_cnt0 != {STAT_W{1'b1}})) begin
                stat_cnt0 <= stat_cnt0 + STAT_W'(1);
            end
            if (gnt1 && (stat_cnt1 != {STAT_W{1'b1}})) begin
                stat_cnt1 <= stat_cnt1 + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed and random checks of ram_arbiter against a transaction-level model
module tb_ram_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata;
    logic          ram_cen, ram_wen;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
`ifdef RAM_ARB_STAT_EN
    logic [STAT_W-1:0] stat_cnt0, stat_cnt1;
`endif

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_cen(ram_cen), .ram_wen(ram_wen),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
`ifdef RAM_ARB_STAT_EN
        , .stat_cnt0(stat_cnt0), .stat_cnt1(stat_cnt1)
`endif
    );

    // Environment: the single-port ram with one cycle of read latency.
    logic [DW-1:0] ram_mem [0:31];
    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) ram_mem[ram_addr] <= ram_din;
            else         ram_dout <= ram_mem[ram_addr];
        end
    end

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rd_t;

    acc_t          q0[$];
    acc_t          q1[$];
    rd_t           rq[$];
    logic [DW-1:0] ref_mem [0:31];
    int            ptr, cyc;
    bit            e_cen, e_wen;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din, e_rdata;
    int            s0, s1;
    int            total = 0;
    int            bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic acc_t rand_acc();
        acc_t a;
        a.we   = 1'($urandom_range(0, 1));
        a.addr = AW'($urandom_range(0, 31));
        a.data = $urandom;
        return a;
    endfunction

    task automatic step(input bit r);
        acc_t a;
        bit   v0, v1, erv0, erv1;
        int   win;
        @(posedge clk);
        #1;
        v0 = (q0.size() > 0);
        v1 = (q1.size() > 0);
        rst  = r;
        req0 = v0;
        req1 = v1;
        if (v0) begin we0 = q0[0].we; addr0 = q0[0].addr; wdata0 = q0[0].data; end
        else    begin we0 = 1'($urandom); addr0 = AW'($urandom); wdata0 = $urandom; end
        if (v1) begin we1 = q1[0].we; addr1 = q1[0].addr; wdata1 = q1[0].data; end
        else    begin we1 = 1'($urandom); addr1 = AW'($urandom); wdata1 = $urandom; end
        @(negedge clk);
        win = -1;
        if (!r) begin
            if (v0 && v1) win = ptr;
            else if (v0)  win = 0;
            else if (v1)  win = 1;
        end
        chk("gnt0", 64'(gnt0), 64'(win == 0));
        chk("gnt1", 64'(gnt1), 64'(win == 1));
        chk("ram_cen", 64'(ram_cen), 64'(e_cen));
        chk("ram_wen", 64'(ram_wen), 64'(e_wen));
        chk("ram_addr", 64'(ram_addr), 64'(e_addr));
        chk("ram_din", 64'(ram_din), 64'(e_din));
        erv0 = 1'b0;
        erv1 = 1'b0;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (!r) begin
                erv0 = (rq[0].id == 0);
                erv1 = (rq[0].id == 1);
                e_rdata = rq[0].data;
            end
            void'(rq.pop_front());
        end
        chk("rvalid0", 64'(rvalid0), 64'(erv0));
        chk("rvalid1", 64'(rvalid1), 64'(erv1));
        chk("rdata", 64'(rdata), 64'(e_rdata));
`ifdef RAM_ARB_STAT_EN
        chk("stat_cnt0", 64'(stat_cnt0), 64'(s0));
        chk("stat_cnt1", 64'(stat_cnt1), 64'(s1));
`endif
        if (r) begin
            ptr = 0; e_cen = 0; e_wen = 0; e_addr = '0; e_din = '0; e_rdata = '0;
            rq.delete();
            s0 = 0; s1 = 0;
        end else begin
            e_cen = (win >= 0);
            if (win >= 0) begin
                a = (win == 0) ? q0.pop_front() : q1.pop_front();
                e_wen  = a.we;
                e_addr = a.addr;
                e_din  = a.data;
                if (a.we) ref_mem[a.addr] = a.data;
                else      rq.push_back('{cyc + 2, win, ref_mem[a.addr]});
                ptr = 1 - win;
                if (win == 0 && s0 < 65535) s0++;
                if (win == 1 && s1 < 65535) s1++;
            end
        end
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0 || rq.size() > 0) && n < 300) begin
            step(1'b0);
            n++;
        end
        step(1'b0);
        chk("drain_timeout", 64'(n < 300), 64'(1));
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            ram_mem[i] = 32'hBAD0_0000 | DW'(i);
            ref_mem[i] = 32'hBAD0_0000 | DW'(i);
        end
        ptr = 0; cyc = 0; e_cen = 0; e_wen = 0; e_addr = '0; e_din = '0; e_rdata = '0;
        s0 = 0; s1 = 0;
        repeat (2) @(posedge clk);
        step(1'b1);

        for (int i = 0; i < 19; i++) q0.push_back('{1'b1, AW'(i), DW'(i)});
        drain();
        for (int i = 0; i < 19; i++) q0.push_back('{1'b0, AW'(i), '0});
        drain();

        for (int i = 0; i < 8; i++) begin
            q0.push_back('{1'b0, AW'(i), '0});
            q1.push_back('{1'b0, AW'(i + 8), '0});
        end
        drain();

        q1.push_back('{1'b1, AW'(5), 32'hDEAD});
        step(1'b0);
        q0.push_back('{1'b0, AW'(5), '0});
        drain();

        q0.push_back('{1'b0, AW'(3), '0});
        step(1'b0);
        step(1'b1);
        q0.push_back('{1'b0, AW'(7), '0});
        q1.push_back('{1'b0, AW'(8), '0});
        drain();

        step(1'b1);
        for (int i = 0; i < 3; i++) q0.push_back('{1'b1, AW'(20 + i), $urandom});
        for (int i = 0; i < 2; i++) q1.push_back('{1'b1, AW'(24 + i), $urandom});
        drain();
        step(1'b1);
        step(1'b0);

        repeat (400) begin
            if ($urandom_range(0, 2) == 0 && q0.size() < 3) q0.push_back(rand_acc());
            if ($urandom_range(0, 2) == 0 && q1.size() < 3) q1.push_back(rand_acc());
            step($urandom_range(0, 99) == 0);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
